// File: rtl/vx_mem_req_arb.sv
// vx_mem_req_arb: round-robin arbiter sharing one dcache request/response channel among NUM_REQS clients.
// Optional perf counters (perf_stall_cycles, perf_full_cycles) are enabled by defining VX_MEM_ARB_PERF_EN.
module vx_mem_req_arb #(
    parameter int NUM_REQS     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_IN_WIDTH = 8,
    parameter int MAX_PENDING  = 16,
`ifdef VX_MEM_ARB_PERF_EN
    parameter int PERF_CTR_BITS = 32,
`endif
    localparam int IDX_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int CNT_W     = $clog2(MAX_PENDING + 1),
    localparam int TAG_OUT_W = TAG_IN_WIDTH + IDX_W
) (
    input  logic                             clk,
    input  logic                             reset_n,

    input  logic [NUM_REQS-1:0]              in_req_valid,
    input  logic [NUM_REQS-1:0]              in_req_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   in_req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   in_req_data,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] in_req_tag,
    output logic [NUM_REQS-1:0]              in_req_ready,

    output logic                             out_req_valid,
    output logic                             out_req_rw,
    output logic [ADDR_WIDTH-1:0]            out_req_addr,
    output logic [DATA_WIDTH-1:0]            out_req_data,
    output logic [TAG_OUT_W-1:0]             out_req_tag,
    input  logic                             out_req_ready,

    input  logic                             out_rsp_valid,
    input  logic [DATA_WIDTH-1:0]            out_rsp_data,
    input  logic [TAG_OUT_W-1:0]             out_rsp_tag,
    output logic                             out_rsp_ready,

    output logic [NUM_REQS-1:0]              in_rsp_valid,
    output logic [DATA_WIDTH-1:0]            in_rsp_data,
    output logic [TAG_IN_WIDTH-1:0]          in_rsp_tag,
    input  logic [NUM_REQS-1:0]              in_rsp_ready,

    output logic [CNT_W-1:0]                 pending_count,
    output logic                             busy
`ifdef VX_MEM_ARB_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]         perf_stall_cycles,
    output logic [PERF_CTR_BITS-1:0]         perf_full_cycles
`endif
);

    logic                    load_en;
    logic                    rd_full;
    logic [NUM_REQS-1:0]     eligible;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        next_ptr;
    logic                    grant_found;
    logic                    accept;
    logic                    sel_rw;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [TAG_IN_WIDTH-1:0] sel_tag;
    logic                    rd_inc;
    logic                    rsp_fire;
    logic [IDX_W-1:0]        rsp_idx;
    logic                    rsp_hit;

    assign load_en  = ~out_req_valid | out_req_ready;
    assign rd_full  = (pending_count == CNT_W'(MAX_PENDING));
    assign eligible = in_req_valid & (in_req_rw | {NUM_REQS{~rd_full}});

    // Scan eligible requesters starting at rr_ptr, wrapping modulo NUM_REQS.
    always_comb begin : grant_scan
        int pos;
        pos         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQS) begin
                pos = pos - NUM_REQS;
            end
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!grant_found && (pos == i) && eligible[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign accept   = grant_found & load_en;
    assign next_ptr = (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + 1'b1;

    always_comb begin
        in_req_ready = '0;
        sel_rw       = 1'b0;
        sel_addr     = '0;
        sel_data     = '0;
        sel_tag      = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                in_req_ready[i] = accept;
                sel_rw          = in_req_rw[i];
                sel_addr        = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data        = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_tag         = in_req_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
            end
        end
    end

    // Single output register stage; holds its contents while the downstream stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_req_valid <= 1'b0;
            out_req_rw    <= 1'b0;
            out_req_addr  <= '0;
            out_req_data  <= '0;
            out_req_tag   <= '0;
            rr_ptr        <= '0;
        end else if (load_en) begin
            out_req_valid <= accept;
            if (accept) begin
                out_req_rw   <= sel_rw;
                out_req_addr <= sel_addr;
                out_req_data <= sel_data;
                out_req_tag  <= {sel_tag, grant_idx};
                rr_ptr       <= next_ptr;
            end
        end
    end

    assign rd_inc   = accept & ~sel_rw;
    assign rsp_fire = out_rsp_valid & out_rsp_ready;

    // Saturating decrement absorbs stale responses that arrive after a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_count <= '0;
        end else begin
            case ({rd_inc, rsp_fire})
                2'b10:   pending_count <= pending_count + 1'b1;
                2'b01:   if (pending_count != '0) pending_count <= pending_count - 1'b1;
                default: pending_count <= pending_count;
            endcase
        end
    end

    assign busy = out_req_valid | (pending_count != '0);

    assign rsp_idx     = out_rsp_tag[IDX_W-1:0];
    assign in_rsp_data = out_rsp_data;
    assign in_rsp_tag  = out_rsp_tag[TAG_OUT_W-1:IDX_W];

    // An index with no matching requester is accepted and dropped.
    always_comb begin
        rsp_hit       = 1'b0;
        out_rsp_ready = 1'b1;
        in_rsp_valid  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rsp_idx == IDX_W'(i)) begin
                rsp_hit         = 1'b1;
                out_rsp_ready   = in_rsp_ready[i];
                in_rsp_valid[i] = out_rsp_valid;
            end
        end
    end

    rsp_idx_in_range: assert property (@(posedge clk) disable iff (!reset_n) out_rsp_valid |-> rsp_hit);

`ifdef VX_MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
            perf_full_cycles  <= '0;
        end else begin
            if ((|in_req_valid) && !(|in_req_ready)) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
            if (rd_full) begin
                perf_full_cycles <= perf_full_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_mem_req_arb.sv
// tb_vx_mem_req_arb: directed scenarios plus randomized traffic checked against a cycle-level reference model.
module tb_vx_mem_req_arb;
    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TW   = 8;
    localparam int MAXP = 4;
    localparam int IW   = 2;
    localparam int CW   = 3;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [N-1:0]         in_req_valid, in_req_rw, in_req_ready;
    logic [N*AW-1:0]      in_req_addr;
    logic [N*DW-1:0]      in_req_data;
    logic [N*TW-1:0]      in_req_tag;
    logic                 out_req_valid, out_req_rw, out_req_ready;
    logic [AW-1:0]        out_req_addr;
    logic [DW-1:0]        out_req_data;
    logic [TW+IW-1:0]     out_req_tag;
    logic                 out_rsp_valid, out_rsp_ready;
    logic [DW-1:0]        out_rsp_data;
    logic [TW+IW-1:0]     out_rsp_tag;
    logic [N-1:0]         in_rsp_valid, in_rsp_ready;
    logic [DW-1:0]        in_rsp_data;
    logic [TW-1:0]        in_rsp_tag;
    logic [CW-1:0]        pending_count;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    vx_mem_req_arb #(
        .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW), .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
        .in_req_data(in_req_data), .in_req_tag(in_req_tag), .in_req_ready(in_req_ready),
        .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
        .out_req_data(out_req_data), .out_req_tag(out_req_tag), .out_req_ready(out_req_ready),
        .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
        .out_rsp_ready(out_rsp_ready),
        .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
        .in_rsp_ready(in_rsp_ready),
        .pending_count(pending_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] rw, input logic ordy,
                                 input logic rv, input logic [TW+IW-1:0] rtag, input logic [N-1:0] rrdy);
        @(posedge clk);
        #1;
        in_req_valid  = v;
        in_req_rw     = rw;
        out_req_ready = ordy;
        out_rsp_valid = rv;
        out_rsp_tag   = rtag;
        in_rsp_ready  = rrdy;
        out_rsp_data  = $urandom;
        for (int i = 0; i < N; i++) begin
            in_req_addr[i*AW +: AW] = $urandom;
            in_req_data[i*DW +: DW] = $urandom;
            in_req_tag[i*TW +: TW]  = TW'($urandom);
        end
    endtask

    task automatic doReset();
        applyStimulus('0, '0, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Reference model: arbitration pointer, buffered request and outstanding-read count as plain integers.
    int               m_valid = 0;
    int               m_ptr = 0;
    int               m_pending = 0;
    logic             m_rw;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_data;
    logic [TW+IW-1:0] m_tag;

    always @(negedge clk) begin
        int           g;
        int           j;
        bit           load, full, acc, rd, fire, exp_rrdy;
        logic [N-1:0] exp_ready, exp_rvalid;
        if (!reset_n) begin
            m_valid   = 0;
            m_ptr     = 0;
            m_pending = 0;
        end
        load = (m_valid == 0) || out_req_ready;
        full = (m_pending == MAXP);
        g    = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            for (int i = 0; i < N; i++) begin
                if (g < 0 && i == j && in_req_valid[i] && (in_req_rw[i] || !full)) g = i;
            end
        end
        acc = (g >= 0) && load;
        for (int i = 0; i < N; i++) begin
            exp_ready[i]  = acc && (i == g);
            exp_rvalid[i] = out_rsp_valid && (out_rsp_tag[IW-1:0] == IW'(i));
        end
        exp_rrdy = in_rsp_ready[out_rsp_tag[IW-1:0]];
        fire     = out_rsp_valid && exp_rrdy;

        checkOutput("in_req_ready", 64'(in_req_ready), 64'(exp_ready));
        checkOutput("out_req_valid", 64'(out_req_valid), 64'(m_valid));
        if (m_valid != 0) begin
            checkOutput("out_req_rw", 64'(out_req_rw), 64'(m_rw));
            checkOutput("out_req_addr", 64'(out_req_addr), 64'(m_addr));
            checkOutput("out_req_data", 64'(out_req_data), 64'(m_data));
            checkOutput("out_req_tag", 64'(out_req_tag), 64'(m_tag));
        end
        checkOutput("pending_count", 64'(pending_count), 64'(m_pending));
        checkOutput("busy", 64'(busy), 64'((m_valid != 0) || (m_pending != 0)));
        checkOutput("in_rsp_valid", 64'(in_rsp_valid), 64'(exp_rvalid));
        checkOutput("out_rsp_ready", 64'(out_rsp_ready), 64'(exp_rrdy));
        checkOutput("in_rsp_tag", 64'(in_rsp_tag), 64'(out_rsp_tag[IW +: TW]));
        checkOutput("in_rsp_data", 64'(in_rsp_data), 64'(out_rsp_data));

        if (reset_n) begin
            rd = 1'b0;
            if (load) begin
                m_valid = acc ? 1 : 0;
                for (int i = 0; i < N; i++) begin
                    if (acc && i == g) begin
                        m_rw   = in_req_rw[i];
                        m_addr = in_req_addr[i*AW +: AW];
                        m_data = in_req_data[i*DW +: DW];
                        m_tag  = {in_req_tag[i*TW +: TW], IW'(i)};
                        rd     = !in_req_rw[i];
                    end
                end
                if (acc) m_ptr = (g + 1) % N;
            end
            if (rd && !fire) m_pending = m_pending + 1;
            else if (!rd && fire && m_pending > 0) m_pending = m_pending - 1;
        end
    end

    logic [N-1:0]  exp_onehot;
    logic [AW-1:0] held_addr;

    initial begin
        reset_n       = 1'b0;
        in_req_valid  = '0;
        in_req_rw     = '0;
        in_req_addr   = '0;
        in_req_data   = '0;
        in_req_tag    = '0;
        out_req_ready = 1'b0;
        out_rsp_valid = 1'b0;
        out_rsp_data  = '0;
        out_rsp_tag   = '0;
        in_rsp_ready  = '0;

        // Reset state
        doReset();
        @(negedge clk);
        checkOutput("reset_valid", 64'(out_req_valid), 64'd0);
        checkOutput("reset_pending", 64'(pending_count), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);

        // Single read from requester 1
        applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b0, '0, '0);
        in_req_addr[AW +: AW] = 32'h100;
        in_req_tag[TW +: TW]  = 8'h05;
        @(negedge clk);
        checkOutput("single_ready", 64'(in_req_ready), 64'h2);
        applyStimulus('0, '0, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("single_valid", 64'(out_req_valid), 64'd1);
        checkOutput("single_addr", 64'(out_req_addr), 64'h100);
        checkOutput("single_tag", 64'(out_req_tag), 64'h015);
        checkOutput("single_rw", 64'(out_req_rw), 64'd0);
        checkOutput("single_pending", 64'(pending_count), 64'd1);

        // Round-robin with all four requesters writing continuously
        doReset();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'hF, 4'hF, 1'b1, 1'b0, '0, '0);
            @(negedge clk);
            exp_onehot = 4'b0001 << (k % 4);
            checkOutput("rr_grant", 64'(in_req_ready), 64'(exp_onehot));
            if (k > 0) checkOutput("rr_out_idx", 64'(out_req_tag[IW-1:0]), 64'((k - 1) % 4));
            if (k == 7) held_addr = in_req_addr[3*AW +: AW];
        end

        // Backpressure: buffered request from requester 3 must hold
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'hF, 4'hF, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            checkOutput("bp_ready", 64'(in_req_ready), 64'd0);
            checkOutput("bp_valid", 64'(out_req_valid), 64'd1);
            checkOutput("bp_addr", 64'(out_req_addr), 64'(held_addr));
            checkOutput("bp_idx", 64'(out_req_tag[IW-1:0]), 64'd3);
        end
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("bp_resume", 64'(in_req_ready), 64'h1);

        // Read throttle at MAX_PENDING=4
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, '0, '0);
            @(negedge clk);
            checkOutput("thr_fill", 64'(in_req_ready), 64'h1);
        end
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("thr_full_pending", 64'(pending_count), 64'd4);
        checkOutput("thr_read_blocked", 64'(in_req_ready), 64'd0);
        applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("thr_write_ok", 64'(in_req_ready), 64'h1);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b1, 10'h2A8, 4'b0001);
        @(negedge clk);
        checkOutput("thr_rsp_pending", 64'(pending_count), 64'd4);
        checkOutput("thr_rsp_ready", 64'(out_rsp_ready), 64'd1);
        checkOutput("thr_still_blocked", 64'(in_req_ready), 64'd0);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("thr_drained", 64'(pending_count), 64'd3);
        checkOutput("thr_read_ok", 64'(in_req_ready), 64'h1);
        applyStimulus('0, '0, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("thr_refull", 64'(pending_count), 64'd4);

        // Response routing to requester 2
        applyStimulus('0, '0, 1'b1, 1'b1, 10'h0F2, 4'b1011);
        @(negedge clk);
        checkOutput("route_valid", 64'(in_rsp_valid), 64'h4);
        checkOutput("route_stall", 64'(out_rsp_ready), 64'd0);
        applyStimulus('0, '0, 1'b1, 1'b1, 10'h0F2, 4'b1111);
        @(negedge clk);
        checkOutput("route_ready", 64'(out_rsp_ready), 64'd1);
        checkOutput("route_tag", 64'(in_rsp_tag), 64'h3C);

        // Reset with a buffered request and three reads outstanding
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("mid_accept", 64'(in_req_ready), 64'h2);
        applyStimulus('0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("mid_valid_pre", 64'(out_req_valid), 64'd1);
        checkOutput("mid_pending_pre", 64'(pending_count), 64'd3);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("mid_valid_rst", 64'(out_req_valid), 64'd0);
        checkOutput("mid_pending_rst", 64'(pending_count), 64'd0);
        checkOutput("mid_busy_rst", 64'(busy), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b1, 10'h001, 4'b0010);
        @(negedge clk);
        checkOutput("stale_ready", 64'(out_rsp_ready), 64'd1);
        applyStimulus('0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("stale_pending", 64'(pending_count), 64'd0);

        // Randomized traffic: sparse responses first to exercise the throttle, then heavier
        for (int c = 0; c < 4000; c++) begin
            logic rv;
            rv = (c < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            applyStimulus(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0), rv,
                          (TW+IW)'($urandom), N'($urandom));
            reset_n = ($urandom_range(0, 599) != 0);
        end

        applyStimulus('0, '0, 1'b1, 1'b0, '0, '0);
        reset_n = 1'b1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
